acc_requant: RTL and testbench

- Downstream stage of the systolic-array CFU.
- Consumes 128-bit accumulator rows (4 lanes × int32) as they are drained from the C global buffer.
- Applies TFLite-style int8 requantization per lane: bias add, fixed-point multiply, rounding shift, output offset, activation clamp.
- Emits one packed 32-bit word of four int8 results per row, so the CPU reads one word per row instead of four.

---
 rtl/acc_requant.sv | 135 +++++++++++++
 tb/tb_acc_requant.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/acc_requant.sv
// acc_requant: 4-stage int8 requantizer packing one int32 accumulator row per output word.
// Defining ACC_REQUANT_SAT_CNT_EN adds the sat_count clamp-event counter.
module acc_requant #(
  parameter int LANES = 4,
  parameter int ACC_BITS = 32
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      cfg_wr,
  input  logic [2:0]                cfg_addr,
  input  logic [31:0]               cfg_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [LANES*ACC_BITS-1:0] in_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [8*LANES-1:0]        out_data,
  output logic                      busy
`ifdef ACC_REQUANT_SAT_CNT_EN
  ,
  output logic [15:0]               sat_count
`endif
);
  localparam int A = ACC_BITS;
  localparam logic signed [A-1:0] MIN = {1'b1, {(A-1){1'b0}}};
  localparam logic [A-1:0] ONE = {{(A-1){1'b0}}, 1'b1};
  localparam logic signed [2*A-1:0] NPOS = {{(A+1){1'b0}}, 1'b1, {(A-2){1'b0}}};
  localparam logic signed [2*A-1:0] NNEG = {{(2*A-1){1'b0}}, 1'b1} - NPOS;
  logic r_v1, r_v2, r_v3, r_v4;
  logic signed [A-1:0] r_bias [LANES];
  logic signed [A-1:0] r_mult, r_off;
  logic [4:0] r_shift;
  logic signed [7:0] r_amin, r_amax;
  logic signed [A-1:0] r_x [LANES];
  logic signed [2*A-1:0] r_p [LANES];
  logic [LANES-1:0] r_ovf;
  logic signed [A-1:0] r_h [LANES];
  logic [8*LANES-1:0] r_out;
  logic w_stall;
  logic signed [A-1:0] w_h [LANES];
  logic [8*LANES-1:0] w_pk;
  logic [A-1:0] w_mask;
  logic signed [A:0] w_mn, w_mx;
`ifdef ACC_REQUANT_SAT_CNT_EN
  logic [LANES-1:0] w_cl;
`endif
  assign w_stall = r_v4 & ~out_ready;
  assign in_ready = ~w_stall;
  assign out_valid = r_v4;
  assign out_data = r_out;
  assign busy = r_v1 | r_v2 | r_v3 | r_v4;
  assign w_mask = (ONE << r_shift) - ONE;
  assign w_mn = $signed({{(A-7){r_amin[7]}}, r_amin});
  assign w_mx = $signed({{(A-7){r_amax[7]}}, r_amax});
  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic signed [2*A-1:0] w_s;
    logic signed [A-1:0] w_sh, w_r;
    logic [A-1:0] w_rem, w_thr;
    logic signed [A:0] w_v, w_c;
    logic w_lo, w_hi;
    // floor shift plus one for negative inexact values gives truncation toward zero
    assign w_s = r_p[g] + (r_p[g][2*A-1] ? NNEG : NPOS);
    assign w_h[g] = r_ovf[g] ? ~MIN
                             : w_s[2*A-2:A-1] + {{(A-1){1'b0}}, w_s[2*A-1] & (|w_s[A-2:0])};
    assign w_sh = r_h[g] >>> r_shift;
    assign w_rem = r_h[g] & w_mask;
    assign w_thr = (w_mask >> 1) + {{(A-1){1'b0}}, r_h[g][A-1]};
    assign w_r = w_sh + {{(A-1){1'b0}}, w_rem > w_thr};
    assign w_v = {w_r[A-1], w_r} + {r_off[A-1], r_off};
    assign w_lo = w_v < w_mn;
    assign w_c = w_lo ? w_mn : w_v;
    assign w_hi = w_c > w_mx;
    assign w_pk[8*g+:8] = w_hi ? r_amax : w_c[7:0];
`ifdef ACC_REQUANT_SAT_CNT_EN
    assign w_cl[g] = w_lo | w_hi;
`endif
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      {r_v1, r_v2, r_v3, r_v4} <= '0;
      r_mult <= {2'b01, {(A-2){1'b0}}};
      r_shift <= '0;
      r_off <= '0;
      r_amin <= 8'sh80;
      r_amax <= 8'sh7f;
      r_ovf <= '0;
      r_out <= '0;
      for (int l = 0; l < LANES; l++) begin
        r_bias[l] <= '0;
        r_x[l] <= '0;
        r_p[l] <= '0;
        r_h[l] <= '0;
      end
    end else begin
      if (cfg_wr) begin
        for (int l = 0; l < LANES; l++) if (cfg_addr == 3'(l)) r_bias[l] <= cfg_data;
        if (cfg_addr == 3'd4) r_mult <= cfg_data;
        if (cfg_addr == 3'd5) r_shift <= cfg_data[4:0];
        if (cfg_addr == 3'd6) r_off <= cfg_data;
        if (cfg_addr == 3'd7) {r_amax, r_amin} <= cfg_data[15:0];
      end
      if (!w_stall) begin
        r_v1 <= in_valid;
        r_v2 <= r_v1;
        r_v3 <= r_v2;
        r_v4 <= r_v3;
        for (int l = 0; l < LANES; l++) begin
          r_x[l] <= in_data[A*l+:A] + r_bias[l];
          r_p[l] <= $signed({{A{r_x[l][A-1]}}, r_x[l]}) * $signed({{A{r_mult[A-1]}}, r_mult});
          r_ovf[l] <= (r_x[l] == MIN) && (r_mult == MIN);
          r_h[l] <= w_h[l];
        end
        r_out <= w_pk;
      end
    end
  end
`ifdef ACC_REQUANT_SAT_CNT_EN
  localparam int CW = $clog2(LANES + 1);
  logic [CW-1:0] r_ncl;
  logic [15:0] r_sat;
  logic [16:0] w_sum;
  assign w_sum = {1'b0, r_sat} + 17'(r_ncl);
  assign sat_count = r_sat;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ncl <= '0;
      r_sat <= '0;
    end else begin
      if (!w_stall) r_ncl <= CW'($countones(w_cl));
      if (cfg_wr && cfg_addr == 3'd7) r_sat <= '0;
      else if (r_v4 && !w_stall) r_sat <= w_sum[16] ? 16'hffff : w_sum[15:0];
    end
  end
`endif
endmodule

// File: tb/tb_acc_requant.sv
// tb_acc_requant: directed and streamed rows for acc_requant, scored against a queue of expected words.
module tb_acc_requant;
  logic clk = 1'b0;
  logic reset, cfg_wr, in_valid, in_ready, out_valid, out_ready, busy;
  logic [2:0] cfg_addr;
  logic [31:0] cfg_data, out_data;
  logic [127:0] in_data;
`ifdef ACC_REQUANT_SAT_CNT_EN
  logic [15:0] sat_count;
`endif
  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  int m_bias[4];
  int m_mult, m_shift, m_off, m_min, m_max;

  acc_requant dut (
    .clk(clk), .reset(reset), .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy)
`ifdef ACC_REQUANT_SAT_CNT_EN
    , .sat_count(sat_count)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic model_defaults();
    for (int i = 0; i < 4; i++) m_bias[i] = 0;
    m_mult = 32'h40000000;
    m_shift = 0;
    m_off = 0;
    m_min = -128;
    m_max = 127;
  endtask

  // reference: exact-integer arithmetic, round-half-away-from-zero for the shift
  function automatic logic [31:0] model(input logic [127:0] d);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      int x;
      longint p, n, h, a, q, v;
      x = int'(d[32*i+:32]) + m_bias[i];
      p = longint'(x) * longint'(m_mult);
      n = (p >= 0) ? 64'sd1073741824 : 64'sd1 - 64'sd1073741824;
      if (x == int'(32'h80000000) && m_mult == int'(32'h80000000)) h = 64'sd2147483647;
      else h = (p + n) / 64'sd2147483648;
      a = (h < 0) ? -h : h;
      q = (m_shift == 0) ? a : (a + (64'sd1 << (m_shift - 1))) >>> m_shift;
      v = ((h < 0) ? -q : q) + longint'(m_off);
      if (v < m_min) v = m_min;
      if (v > m_max) v = m_max;
      res[8*i+:8] = v[7:0];
    end
    return res;
  endfunction

  function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
    return {d, c, b, a};
  endfunction

  task automatic cfg(input logic [2:0] a, input logic [31:0] d);
    cfg_wr = 1'b1;
    cfg_addr = a;
    cfg_data = d;
    @(negedge clk);
    cfg_wr = 1'b0;
    if (a < 3'd4) m_bias[a] = d;
    if (a == 3'd4) m_mult = d;
    if (a == 3'd5) m_shift = int'(d[4:0]);
    if (a == 3'd6) m_off = d;
    if (a == 3'd7) begin
      m_min = $signed(d[7:0]);
      m_max = $signed(d[15:8]);
    end
  endtask

  task automatic send(input logic [127:0] d, input logic [31:0] exp);
    int n = 0;
    in_valid = 1'b1;
    in_data = d;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) chk("in_ready_timeout", {31'b0, in_ready}, 32'd1);
    sb.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while ((sb.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_busy", {31'b0, busy}, 32'd0);
    chk("drain_sb", sb.size(), 32'd0);
  endtask

  always @(negedge clk) begin
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", sb.size(), 32'd1);
      else chk("row", out_data, sb.pop_front());
    end
  end

  initial begin
    int n;
    reset = 1'b1;
    cfg_wr = 1'b0;
    cfg_addr = '0;
    cfg_data = '0;
    in_valid = 1'b0;
    in_data = '0;
    out_ready = 1'b1;
    model_defaults();
    repeat (2) @(negedge clk);
    chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_out_data", out_data, 32'd0);
    reset = 1'b0;
    @(negedge clk);
    send(pk(100, -100, 0, 1000), 32'h7F00CE32);
    n = 1;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("latency", n, 32'd4);
    drain();
`ifdef ACC_REQUANT_SAT_CNT_EN
    chk("sat_count", {16'b0, sat_count}, 32'd1);
`endif
    cfg(3'd4, 32'h7FFFFFFF);
    cfg(3'd5, 32'd2);
    send(pk(6, -6, 5, -5), 32'hFF01FE02);
    drain();
    cfg(3'd0, 32'd10);
    cfg(3'd5, 32'd0);
    cfg(3'd6, 32'hFFFFFF80);
    cfg(3'd7, 32'h00007F80);
    send(pk(-10, 0, 300, 0), 32'h807F8080);
    drain();
    cfg(3'd7, 32'h00001020);
    send(pk(1, 2, 3, 4), 32'h10101010);
    drain();
    cfg(3'd7, 32'h00007F80);
    cfg_wr = 1'b1;
    cfg_addr = 3'd0;
    cfg_data = 32'd0;
    in_valid = 1'b1;
    in_data = pk(118, 0, 0, 0);
    sb.push_back(32'h80808000);
    @(negedge clk);
    cfg_wr = 1'b0;
    in_valid = 1'b0;
    m_bias[0] = 0;
    drain();
    cfg(3'd4, 32'h80000000);
    cfg(3'd6, 32'd0);
    send(pk(int'(32'h80000000), 0, 0, 0), 32'h0000007F);
    drain();
    cfg(3'd4, 32'h5A000000);
    cfg(3'd5, 32'd3);
    cfg(3'd6, 32'd5);
    cfg(3'd7, 32'h00006AA0);
    fork
      begin : g_src
        logic [127:0] d;
        for (int r = 0; r < 8; r++) begin
          d = pk(int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000,
                 int'($urandom_range(0, 4000)) - 2000, int'($urandom_range(0, 4000)) - 2000);
          send(d, model(d));
        end
      end
      begin : g_stall
        int k;
        logic [31:0] hold;
        k = 0;
        do begin
          @(posedge clk);
          #1;
          k++;
        end while (!out_valid && k < 20);
        chk("stall_seen", {31'b0, out_valid}, 32'd1);
        out_ready = 1'b0;
        hold = out_data;
        repeat (5) begin
          @(negedge clk);
          chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
          chk("stall_hold", out_data, hold);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    send(pk(5, 6, 7, 8), model(pk(5, 6, 7, 8)));
    send(pk(9, 10, 11, 12), model(pk(9, 10, 11, 12)));
    send(pk(13, 14, 15, 16), model(pk(13, 14, 15, 16)));
    chk("busy_inflight", {31'b0, busy}, 32'd1);
    reset = 1'b1;
    #1;
    chk("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, busy}, 32'd0);
    chk("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
`ifdef ACC_REQUANT_SAT_CNT_EN
    chk("sat_reset", {16'b0, sat_count}, 32'd0);
`endif
    sb.delete();
    model_defaults();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    send(pk(100, -100, 0, 1000), 32'h7F00CE32);
    drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
